round_referee: RTL and testbench

- Produces the per-player `win` pulses that each player's win counter consumes.
- Samples the playfield edge lights and the per-player press pulses, and decides when a round is won.
- After a win, holds the playfield for a fixed time, then pulses `roundReset` to re-centre the light.
- Once either counter reports game over, it freezes in a terminal state until system reset.

---
 rtl/referee_pkg.sv | 14 +
 rtl/round_referee_hold_timer.sv | 33 +++
 rtl/round_referee.sv | 131 +++++++++++++
 tb/tb_round_referee.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/referee_pkg.sv
// Shared types for the round referee: FSM states and last-winner encodings.
package referee_pkg;

    typedef enum logic [1:0] {
        PLAY = 2'b00,
        HOLD = 2'b01,
        OVER = 2'b10
    } state_e;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b01;
    localparam logic [1:0] WIN_RIGHT = 2'b10;

endpackage

// File: rtl/round_referee_hold_timer.sv
// Loadable down-counter that times the post-win hold; saturates at zero.
module hold_timer #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic done
);

    localparam int CW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] ZERO     = {CW{1'b0}};

    logic [CW-1:0] r_count;

    // Count register: load on a win, then count down to zero and stay there.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= ZERO;
        end else if (load) begin
            r_count <= LOAD_VAL;
        end else if (en && (r_count != ZERO)) begin
            r_count <= r_count - CW'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign done = en & (r_count == ZERO);

endmodule

// File: rtl/round_referee.sv
// Round referee: detects round wins, times the hold, re-centres the light and
// freezes once either win counter reports game over.
module round_referee
    import referee_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lightL,
    input  logic       lightR,
    input  logic       pressL,
    input  logic       pressR,
    input  logic       gameOverL,
    input  logic       gameOverR,
    output logic       winL,
    output logic       winR,
    output logic       roundReset,
    output logic       over,
    output logic [1:0] lastWinner
);

    state_e     r_state;
    logic       r_winL;
    logic       r_winR;
    logic       r_roundReset;
    logic       r_over;
    logic [1:0] r_lastWinner;

    state_e     w_next;
    logic       w_winL;
    logic       w_winR;
    logic       w_roundReset;
    logic [1:0] w_lastWinner;
    logic       w_load;
    logic       w_en;
    logic       w_done;
    logic       w_gameOver;
    logic       w_qualL;
    logic       w_qualR;

    // A win needs the player's own edge lit, only that player pressing, and a legal field.
    assign w_gameOver = gameOverL | gameOverR;
    assign w_qualL    = lightL & pressL & ~pressR & ~lightR;
    assign w_qualR    = lightR & pressR & ~pressL & ~lightL;

    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk  (clk),
        .reset(reset),
        .load (w_load),
        .en   (w_en),
        .done (w_done)
    );

    // Next-state and next-output decode.
    always_comb begin
        w_next       = r_state;
        w_winL       = 1'b0;
        w_winR       = 1'b0;
        w_roundReset = 1'b0;
        w_lastWinner = r_lastWinner;
        w_load       = 1'b0;
        w_en         = 1'b0;
        case (r_state)
            PLAY: begin
                if (w_gameOver) begin
                    w_next = OVER;
                end else if (w_qualL) begin
                    w_next       = HOLD;
                    w_winL       = 1'b1;
                    w_lastWinner = WIN_LEFT;
                    w_load       = 1'b1;
                end else if (w_qualR) begin
                    w_next       = HOLD;
                    w_winR       = 1'b1;
                    w_lastWinner = WIN_RIGHT;
                    w_load       = 1'b1;
                end else begin
                    w_next = PLAY;
                end
            end
            HOLD: begin
                w_en = 1'b1;
                if (w_done) begin
                    if (w_gameOver) begin
                        w_next = OVER;
                    end else begin
                        w_next       = PLAY;
                        w_roundReset = 1'b1;
                    end
                end else begin
                    w_next = HOLD;
                end
            end
            OVER: begin
                w_next = OVER;
            end
            default: begin
                w_next = PLAY;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= PLAY;
            r_winL       <= 1'b0;
            r_winR       <= 1'b0;
            r_roundReset <= 1'b0;
            r_over       <= 1'b0;
            r_lastWinner <= WIN_NONE;
        end else begin
            r_state      <= w_next;
            r_winL       <= w_winL;
            r_winR       <= w_winR;
            r_roundReset <= w_roundReset;
            r_over       <= (w_next == OVER);
            r_lastWinner <= w_lastWinner;
        end
    end

    assign winL       = r_winL;
    assign winR       = r_winR;
    assign roundReset = r_roundReset;
    assign over       = r_over;
    assign lastWinner = r_lastWinner;

endmodule

// File: tb/tb_round_referee.sv
// Directed bench for round_referee with a cycle-level behavioural model and
// hand-computed spot checks.
module tb_round_referee;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       lightL, lightR, pressL, pressR;
    logic       gameOverL, gameOverR;
    logic       winL, winR, roundReset, over;
    logic [1:0] lastWinner;

    int vectors = 0;
    int fails   = 0;

    // Left win counter hooked to winL: saturating 0..7, gameOver at 7.
    logic [2:0] score;

    // Model state and expected outputs.
    int         m_hold  = 0;
    bit         m_ended = 1'b0;
    bit         m_valid = 1'b0;
    logic       e_winL = 1'b0, e_winR = 1'b0, e_rr = 1'b0, e_over = 1'b0;
    logic [1:0] e_lw = 2'b00;

    round_referee #(.HOLD_CYCLES(HOLD)) dut (
        .clk       (clk),
        .reset     (reset),
        .lightL    (lightL),
        .lightR    (lightR),
        .pressL    (pressL),
        .pressR    (pressR),
        .gameOverL (gameOverL),
        .gameOverR (gameOverR),
        .winL      (winL),
        .winR      (winR),
        .roundReset(roundReset),
        .over      (over),
        .lastWinner(lastWinner)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) score <= 3'd0;
        else if (winL && score != 3'd7) score <= score + 3'd1;
    end
    assign gameOverL = (score == 3'd7);

    // Model: hold_left counts remaining hold samples; ended means game frozen.
    always @(posedge clk) begin : model
        int h;
        bit ended;
        logic wl, wr, rr, ov;
        logic [1:0] lw;
        h = m_hold; ended = m_ended;
        wl = 1'b0; wr = 1'b0; rr = 1'b0; ov = e_over; lw = e_lw;
        if (reset) begin
            h = 0; ended = 1'b0; ov = 1'b0; lw = 2'b00;
        end else if (ended) begin
            ov = 1'b1;
        end else if (h > 0) begin
            h = h - 1;
            if (h == 0) begin
                if (gameOverL || gameOverR) begin ended = 1'b1; ov = 1'b1; end
                else rr = 1'b1;
            end
        end else if (gameOverL || gameOverR) begin
            ended = 1'b1; ov = 1'b1;
        end else if (lightL && pressL && !pressR && !lightR) begin
            wl = 1'b1; lw = 2'b01; h = HOLD;
        end else if (lightR && pressR && !pressL && !lightL) begin
            wr = 1'b1; lw = 2'b10; h = HOLD;
        end
        m_hold  <= h;
        m_ended <= ended;
        e_winL  <= wl;
        e_winR  <= wr;
        e_rr    <= rr;
        e_over  <= ov;
        e_lw    <= lw;
        if (reset) m_valid <= 1'b1;
    end

    // Cycle compare against the model, 1 time unit after each edge.
    always begin
        @(posedge clk);
        #1;
        if (m_valid) begin
            vectors++;
            if ({winL, winR, roundReset, over, lastWinner} !== {e_winL, e_winR, e_rr, e_over, e_lw}) begin
                fails++;
                $display("FAIL model_cycle t=%0t got winL=%b winR=%b rr=%b over=%b lw=%b, expected winL=%b winR=%b rr=%b over=%b lw=%b",
                         $time, winL, winR, roundReset, over, lastWinner, e_winL, e_winR, e_rr, e_over, e_lw);
            end
        end
    end

    task automatic chk(input string name, input logic [2:0] got, input logic [2:0] exp);
        vectors++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %b expected %b", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; lightL = 1'b0; lightR = 1'b0; pressL = 1'b0; pressR = 1'b0; gameOverR = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    int wr_count;

    initial begin
        reset = 1'b1; lightL = 1'b0; lightR = 1'b0; pressL = 1'b0; pressR = 1'b0; gameOverR = 1'b0;
        tick(2);
        chk("reset_outputs", {winL, winR, roundReset}, 3'b000);
        chk("reset_over_lw", {over, lastWinner}, 3'b000);
        reset = 1'b0;
        tick(1);

        // Left win: winL one cycle after the sample, roundReset 4 cycles later.
        lightL = 1'b1; pressL = 1'b1;
        tick(1);
        pressL = 1'b0;
        chk("left_winL", {winL, winR, roundReset}, 3'b100);
        chk("left_lw", {1'b0, lastWinner}, 3'b001);
        tick(1);
        chk("left_winL_pulse", {winL, winR, roundReset}, 3'b000);
        tick(2);
        chk("left_no_early_rr", {2'b00, roundReset}, 3'b000);
        tick(1);
        chk("left_rr", {winL, winR, roundReset}, 3'b001);
        lightL = 1'b0;
        tick(1);

        // Simultaneous presses: no win.
        lightR = 1'b1; pressL = 1'b1; pressR = 1'b1;
        tick(1);
        pressL = 1'b0; pressR = 1'b0;
        chk("simul_no_win", {winL, winR, roundReset}, 3'b000);
        chk("simul_lw_kept", {1'b0, lastWinner}, 3'b001);

        // Illegal both-lights field: no win.
        lightL = 1'b1; pressR = 1'b1;
        tick(1);
        pressR = 1'b0; lightL = 1'b0;
        chk("both_lights_no_win", {winL, winR, roundReset}, 3'b000);

        // Right win with presses held through HOLD: exactly one winR.
        pressR = 1'b1;
        wr_count = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            wr_count += int'(winR);
        end
        pressR = 1'b0;
        tick(1);
        wr_count += int'(winR);
        chk("hold_one_winR", 3'(wr_count), 3'd1);
        chk("hold_rr", {winL, winR, roundReset}, 3'b001);
        lightR = 1'b0;
        tick(1);

        // Game over raised during HOLD: OVER with no roundReset.
        do_reset();
        lightR = 1'b1; pressR = 1'b1;
        tick(1);
        pressR = 1'b0;
        gameOverR = 1'b1;
        tick(4);
        chk("gameover_over", {over, 2'b00}, 3'b100);
        chk("gameover_no_rr", {winL, winR, roundReset}, 3'b000);
        chk("gameover_lw", {1'b0, lastWinner}, 3'b010);
        pressR = 1'b1;
        tick(3);
        pressR = 1'b0;
        chk("over_frozen", {winL, winR, over}, 3'b001);
        lightR = 1'b0;

        // Reset two cycles after winL aborts the round silently.
        do_reset();
        lightL = 1'b1; pressL = 1'b1;
        tick(1);
        pressL = 1'b0;
        chk("midhold_winL", {winL, winR, roundReset}, 3'b100);
        tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("midhold_reset_outs", {winL, winR, roundReset}, 3'b000);
        chk("midhold_reset_lw", {over, lastWinner}, 3'b000);
        lightL = 1'b0;
        tick(6);
        lightL = 1'b1; pressL = 1'b1;
        tick(1);
        pressL = 1'b0;
        chk("midhold_new_win", {winL, 2'b00}, 3'b100);
        tick(4);
        lightL = 1'b0;

        // Seven left wins through the win counter reach game over.
        do_reset();
        for (int w = 0; w < 7; w++) begin
            lightL = 1'b1; pressL = 1'b1;
            tick(1);
            pressL = 1'b0;
            tick(4);
        end
        chk("seven_over", {over, lastWinner}, 3'b101);
        chk("seven_score", score, 3'b111);
        pressL = 1'b1;
        tick(3);
        pressL = 1'b0; lightL = 1'b0;
        tick(1);
        chk("score_held", score, 3'b111);
        chk("seven_over_held", {winL, roundReset, over}, 3'b001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
